// File: rtl/shift_seq_pkg.sv
// ============================================================================
//  Module      : shift_seq_pkg
//  Description : Shared types for the multi-cycle shift sequencer: the
//                shift op-code encoding used by the single-position shift
//                step, and the sequencer FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  // Default datapath geometry.
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_AMT_W  = 4;

  // Shift op-codes; this is the encoding the shift step decodes.
  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_LSL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_ASR  = 2'b11
  } shift_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

endpackage : shift_seq_pkg

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-position shift.
//                  OP_PASS : data unchanged
//                  OP_LSL  : shift left one, zero fill
//                  OP_LSR  : shift right one, zero fill
//                  OP_ASR  : shift right one, sign fill
//  Ports       : data_i  [DATA_W-1:0]  operand
//                op_i    [1:0]         shift op-code (shift_op_e)
//                data_o  [DATA_W-1:0]  operand shifted by one position
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  shift_op_e         op_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_LSL:  data_o = {data_i[DATA_W-2:0], 1'b0};
      OP_LSR:  data_o = {1'b0, data_i[DATA_W-1:1]};
      OP_ASR:  data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule : shift_step

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle shift sequencer. Performs an N-position shift
//                by applying the single-position shift step once per clock.
//                Valid/ready handshake on both the request and result side.
//
//                FSM: IDLE   - accept a request (in_ready=1)
//                     SHIFT  - one step per clock, counting cnt down
//                     DONE   - present result until out_ready
//
//                Build option SHIFT_SEQ_EARLY_EXIT_EN: leave SHIFT (or skip
//                it on accept) as soon as further steps cannot change the
//                data (LSL/LSR: all zeros; ASR: all zeros or all ones).
//                The result value is the same either way; only latency
//                changes. Default build always takes exactly in_amt steps.
//
//  Ports       : clk        in   clock
//                reset      in   asynchronous active-high reset
//                in_valid   in   request valid
//                in_ready   out  sequencer can accept a request
//                in_data    in   [DATA_W-1:0] operand
//                in_op      in   [1:0] 00 pass, 01 LSL, 10 LSR, 11 ASR
//                in_amt     in   [AMT_W-1:0] number of positions
//                out_valid  out  result valid
//                out_ready  in   consumer takes result
//                out_data   out  [DATA_W-1:0] shifted result
//                busy       out  request in flight
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int AMT_W  = DEFAULT_AMT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  seq_state_e        state_q;
  logic [DATA_W-1:0] data_q;
  shift_op_e         op_q;
  logic [AMT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  // Next value of data_q while in SHIFT.
  logic [DATA_W-1:0] data_d;

  shift_op_e         in_op_e;
  logic              accept_to_done;
  logic              shift_to_done;

  assign in_op_e = shift_op_e'(in_op);

  shift_step #(
    .DATA_W (DATA_W)
  ) u_shift_step (
    .data_i (data_q),
    .op_i   (op_q),
    .data_o (data_d)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // True when no further step of op can change d.
  function automatic logic settled(input logic [DATA_W-1:0] d,
                                   input shift_op_e         op);
    logic s;
    case (op)
      OP_LSL,
      OP_LSR:  s = (d == '0);
      OP_ASR:  s = (d == '0) || (&d);
      default: s = 1'b1;
    endcase
    return s;
  endfunction

  // Exit checks look at the value being loaded this edge, so the exit
  // happens on the very edge that produces a settled value.
  always_comb begin
    accept_to_done = (in_amt == '0) || (in_op_e == OP_PASS) ||
                     settled(in_data, in_op_e);
    shift_to_done  = (cnt_q == AMT_W'(1)) || settled(data_d, op_q);
  end
`else
  always_comb begin
    accept_to_done = (in_amt == '0) || (in_op_e == OP_PASS);
    shift_to_done  = (cnt_q == AMT_W'(1));
  end
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM. Handshake outputs are registered alongside the state so
  // they change only at clock edges (or immediately on reset).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= OP_PASS;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            op_q       <= in_op_e;
            cnt_q      <= in_amt;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (accept_to_done) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= SHIFT;
            end
          end
        end

        SHIFT: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - AMT_W'(1);
          if (shift_to_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end

        DONE: begin
          // Result held until taken; no request is accepted in this cycle.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule : shift_seq

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Self-checking bench for shift_seq. A table of directed
//                vectors (operand, op, amount, expected result, expected
//                latency for both builds) plus hand-written sequences for
//                reset, backpressure in DONE and reset abort mid-SHIFT.
//                Latency is counted in clock edges from the accept edge to
//                the edge after which out_valid is seen high (pass / amt=0
//                results are visible in the cycle right after accept).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;
  import shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  shift_seq #(
    .DATA_W (16),
    .AMT_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] exp;
    int          lat;     // default build
    int          lat_ee;  // early-exit build
  } vec_t;

  vec_t vecs[13];

  // One request with out_ready held high; checks result, latency, that
  // in_ready stays low / busy high while in flight, and release afterwards.
  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    bit    stall_ok;
    int    exp_lat;
    string tag;
    tag = $sformatf("v%0d", idx);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    exp_lat = v.lat_ee;
`else
    exp_lat = v.lat;
`endif
    check({tag, "_ready_before"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_op     = v.op;
    in_amt    = v.amt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h5A5A;
    lat      = 0;
    stall_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, v.exp});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_inflight"}, {31'd0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          ok;
    logic [15:0] held;

    //            data      op       amt    exp      lat lat_ee
    vecs[0]  = '{16'h0001, OP_LSL,  4'd4,  16'h0010, 4,  4};
    vecs[1]  = '{16'h8000, OP_ASR,  4'd15, 16'hFFFF, 15, 15};
    vecs[2]  = '{16'h8000, OP_LSR,  4'd15, 16'h0001, 15, 15};
    vecs[3]  = '{16'hBEEF, OP_LSL,  4'd0,  16'hBEEF, 0,  0};
    vecs[4]  = '{16'hBEEF, OP_PASS, 4'd7,  16'hBEEF, 0,  0};
    vecs[5]  = '{16'h0001, OP_LSR,  4'd15, 16'h0000, 15, 1};
    vecs[6]  = '{16'hA5A5, OP_LSL,  4'd1,  16'h4B4A, 1,  1};
    vecs[7]  = '{16'h1234, OP_LSR,  4'd3,  16'h0246, 3,  3};
    vecs[8]  = '{16'h7FF0, OP_ASR,  4'd2,  16'h1FFC, 2,  2};
    vecs[9]  = '{16'h0000, OP_LSL,  4'd5,  16'h0000, 5,  0};
    vecs[10] = '{16'hFFFF, OP_ASR,  4'd9,  16'hFFFF, 9,  0};
    vecs[11] = '{16'hF000, OP_LSL,  4'd4,  16'h0000, 4,  4};
    vecs[12] = '{16'h8001, OP_ASR,  4'd1,  16'hC000, 1,  1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_op     = 2'b00;
    in_amt    = 4'd0;
    out_ready = 1'b1;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {in_ready, out_valid, busy, 13'd0, out_data}, 32'h8000_0000);
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_released", {in_ready, out_valid, busy, 13'd0, out_data}, 32'h8000_0000);

    // ---------------- table ----------------
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // ---------------- backpressure in DONE ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00F0;
    in_op     = OP_LSR;
    in_amt    = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 4);
    check("bp_data", {16'd0, out_data}, 32'h0000_000F);
    held = out_data;
    // A request offered during DONE must be ignored.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_op    = OP_LSL;
    in_amt   = 4'd1;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 ||
          busy !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", {31'd0, ok}, 32'd1);
    check("bp_hold_data", {16'd0, out_data}, 32'h0000_000F);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(posedge clk); #1;
    check("bp_idle_stays", {29'd0, in_ready, out_valid, busy}, 32'd4);
    out_ready = 1'b1;

    // ---------------- reset abort mid-SHIFT ----------------
    in_valid = 1'b1;
    in_data  = 16'h0001;
    in_op    = OP_LSL;
    in_amt   = 4'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_inflight", {29'd0, in_ready, out_valid, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_async", {in_ready, out_valid, busy, 13'd0, out_data}, 32'h8000_0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("abort_no_result", {31'd0, ok}, 32'd1);

    // A fresh request after the abort works normally.
    run_vec(vecs[0], 99);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule : tb_shift_seq

`default_nettype wire
